nibble_add_seq: RTL and testbench

- Sequencer that performs NIBBLES×4-bit add/subtract by time-multiplexing one external 4-bit adder slice (sum[3:0] plus carry-out, no carry-in), one nibble at a time, LSB first.
- The slice's missing carry-in is handled with two adder passes per nibble: operand add, then carry add.
- Sits between a request/response client and the shared adder4 datapath; owns all operand, carry and result registers.

---
 rtl/nibble_add_seq_if.sv | 36 +++
 rtl/nibble_add_seq.sv | 137 +++++++++++++
 tb/tb_nibble_add_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/nibble_add_seq_if.sv
// Request/response, result and shared adder-slice signals of the nibble add sequencer.
// Latency: none, wiring only.
// Backpressure: start_valid/start_ready on requests, res_valid/res_ready on results.
interface nibble_add_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic [3:0]   add_sum;
  logic         add_cy;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_cout;
  logic         res_ovf;
  logic         busy;

  // Client side: issues requests, drives the adder slice, consumes results.
  modport master (
    output start_valid, op_a, op_b, op_sub, add_sum, add_cy, res_ready,
    input  start_ready, add_a, add_b, res_valid, res_data, res_cout, res_ovf, busy
  );

  // Sequencer side.
  modport slave (
    input  start_valid, op_a, op_b, op_sub, add_sum, add_cy, res_ready,
    output start_ready, add_a, add_b, res_valid, res_data, res_cout, res_ovf, busy
  );
endinterface

// File: rtl/nibble_add_seq.sv
// Sequences a NIBBLES*4-bit add/sub through one shared 4-bit adder slice, LSB nibble first.
// Latency: res_valid rises exactly 2*NIBBLES edges after the accept edge.
// Backpressure: result held in DONE until res_ready; no request accepted outside IDLE.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input logic            clk,
  input logic            rst_n,
  nibble_add_seq_if.slave bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, CARRY, DONE} state_t;

  state_t state_q, state_d;

  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] b_q;     // already inverted for subtract
  logic [NIBBLES-1:0][3:0] res_q;
  logic [IDXW-1:0]         idx_q;
  logic [3:0]              partial_q;
  logic                    carry_q;  // carry into the current nibble
  logic                    c1_q;     // carry-out of the operand pass
  logic                    cout_q;
  logic                    ovf_q;

  logic       start_ready_c;
  logic       busy_c;
  logic       res_valid_c;
  logic [3:0] add_a_c;
  logic [3:0] add_b_c;
  logic       carry_next;
  logic       last_nibble;

  // The slice has no carry-in; at most one of the two passes can carry out.
  assign carry_next  = c1_q | bus.add_cy;
  assign last_nibble = (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: the CARRY pass always runs so latency is data independent.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_valid) state_d = ADD;
      ADD:     state_d = CARRY;
      CARRY:   state_d = last_nibble ? DONE : ADD;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; adder inputs are parked at zero when idle.
  always_comb begin
    start_ready_c = 1'b0;
    busy_c        = 1'b0;
    res_valid_c   = 1'b0;
    add_a_c       = 4'h0;
    add_b_c       = 4'h0;
    case (state_q)
      IDLE: start_ready_c = 1'b1;
      ADD: begin
        busy_c  = 1'b1;
        add_a_c = a_q[idx_q];
        add_b_c = b_q[idx_q];
      end
      CARRY: begin
        busy_c  = 1'b1;
        add_a_c = partial_q;
        add_b_c = {3'b000, carry_q};
      end
      DONE:    res_valid_c = 1'b1;
      default: start_ready_c = 1'b0;
    endcase
  end

  // Operand capture, per-nibble partial/carry tracking and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      partial_q <= 4'h0;
      carry_q   <= 1'b0;
      c1_q      <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_sub ? ~bus.op_b : bus.op_b;
            carry_q <= bus.op_sub;
            idx_q   <= '0;
          end
        end
        ADD: begin
          partial_q <= bus.add_sum;
          c1_q      <= bus.add_cy;
        end
        CARRY: begin
          res_q[idx_q] <= bus.add_sum;
          carry_q      <= carry_next;
          if (last_nibble) begin
            // Flags settle with the top nibble so they stay put after retirement.
            cout_q <= carry_next;
            ovf_q  <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                      (bus.add_sum[3] != a_q[NIBBLES-1][3]);
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = start_ready_c;
  assign bus.busy        = busy_c;
  assign bus.res_valid   = res_valid_c;
  assign bus.add_a       = add_a_c;
  assign bus.add_b       = add_b_c;
  assign bus.res_data    = W'(res_q);
  assign bus.res_cout    = cout_q;
  assign bus.res_ovf     = ovf_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq with a behavioural 4-bit adder slice.
// Latency: checks the fixed 2*NIBBLES accept-to-valid latency.
// Backpressure: holds res_ready low in DONE and pulses start_valid there.
module tb_nibble_add_seq;
  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int passed = 0;

  nibble_add_seq_if #(.NIBBLES(4)) bus ();

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Shared adder slice: sum plus carry-out, no carry-in.
  assign {bus.add_cy, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // The operand pass and the carry pass of one nibble must never both carry out.
  int   phase = 0;
  logic c1_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || !bus.busy) begin
      phase = 0;
    end else if (phase == 0) begin
      c1_seen = bus.add_cy;
      phase   = 1;
    end else begin
      check("carry_exclusive", {31'b0, c1_seen & bus.add_cy}, 32'd0);
      phase = 0;
    end
  end

  // Issue one request from IDLE (called #1 after a posedge) and check the result.
  // Retires the result only when res_ready is already high.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic [15:0] ed, input logic ec, input logic eo);
    int lat;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.op_sub      = sub;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.op_a        = 16'hDEAD;
    bus.op_b        = 16'hBEEF;
    bus.op_sub      = ~sub;
    check({tag, "_ready_low_after_accept"}, {31'b0, bus.start_ready}, 32'd0);
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      check({tag, "_ready_low_while_busy"}, {31'b0, bus.start_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_data"}, {16'b0, bus.res_data}, {16'b0, ed});
    check({tag, "_cout"}, {31'b0, bus.res_cout}, {31'b0, ec});
    check({tag, "_ovf"},  {31'b0, bus.res_ovf},  {31'b0, eo});
    if (bus.res_ready) begin
      check({tag, "_ready_low_in_done"}, {31'b0, bus.start_ready}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_idle_after_retire"}, {31'b0, bus.start_ready}, 32'd1);
      check({tag, "_valid_drops"}, {31'b0, bus.res_valid}, 32'd0);
      check({tag, "_data_held"}, {16'b0, bus.res_data}, {16'b0, ed});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.op_a        = 16'h0;
    bus.op_b        = 16'h0;
    bus.op_sub      = 1'b0;
    bus.res_ready   = 1'b1;
    #3;
    check("rst_start_ready", {31'b0, bus.start_ready}, 32'd1);
    check("rst_res_valid",   {31'b0, bus.res_valid},   32'd0);
    check("rst_busy",        {31'b0, bus.busy},        32'd0);
    check("rst_res_data",    {16'b0, bus.res_data},    32'd0);
    check("rst_add_ab",      {24'b0, bus.add_a, bus.add_b}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add_basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("add_ripple", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    do_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    check("idle_add_a_zero", {28'b0, bus.add_a}, 32'd0);
    do_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_pos",    16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Backpressure: result held for five cycles, start_valid pulses ignored.
    bus.res_ready = 1'b0;
    do_op("bp", 16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.start_valid = (i % 2 == 0);
      bus.op_a        = 16'h1111;
      bus.op_b        = 16'h2222;
      bus.op_sub      = 1'b0;
      @(posedge clk); #1;
      check("bp_valid_held", {31'b0, bus.res_valid},   32'd1);
      check("bp_data_held",  {16'b0, bus.res_data},    32'h1000);
      check("bp_cout_held",  {31'b0, bus.res_cout},    32'd1);
      check("bp_ovf_held",   {31'b0, bus.res_ovf},     32'd0);
      check("bp_not_ready",  {31'b0, bus.start_ready}, 32'd0);
    end
    bus.start_valid = 1'b1;
    bus.res_ready   = 1'b1;
    @(posedge clk); #1;
    // The retiring edge must not also accept the still-asserted request.
    bus.start_valid = 1'b0;
    check("bp_idle_after_ready", {31'b0, bus.start_ready}, 32'd1);
    check("bp_no_accept_busy",   {31'b0, bus.busy},        32'd0);
    @(posedge clk); #1;
    check("bp_still_idle", {31'b0, bus.busy}, 32'd0);

    // Abort during the third CARRY pass of 0x1234+0x4321.
    bus.op_a        = 16'h1234;
    bus.op_b        = 16'h4321;
    bus.op_sub      = 1'b0;
    bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
    end
    #1;
    check("abort_busy_before", {31'b0, bus.busy}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_start_ready", {31'b0, bus.start_ready}, 32'd1);
    check("abort_res_valid",   {31'b0, bus.res_valid},   32'd0);
    check("abort_busy",        {31'b0, bus.busy},        32'd0);
    check("abort_res_data",    {16'b0, bus.res_data},    32'd0);
    check("abort_flags",       {30'b0, bus.res_cout, bus.res_ovf}, 32'd0);
    check("abort_add_ab",      {24'b0, bus.add_a, bus.add_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_valid_after", {31'b0, bus.res_valid}, 32'd0);
    do_op("after_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
